// File: rtl/ysyx_23060236_lsu_pkg.sv
// Shared codes for the load/store unit: FSM state encoding, funct3 access
// codes, AXI response codes and the alignment rule used by the optional
// misalignment check (YSYX_23060236_LSU_MISALIGN_EN).
package ysyx_23060236_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4
  } lsu_state_t;

  // funct3 encodings for loads (stores share the low two bits)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] as an access size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Any response other than OKAY is treated as an error; SLVERR is the
  // usual one, but DECERR/EXOKAY are not expected from a data slave either.
  function automatic logic resp_err(input logic [1:0] resp);
    resp_err = (resp != RESP_OKAY) || (resp == RESP_SLVERR);
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_align.sv
// Combinational lane handling for the LSU: byte strobe and data shift for
// stores, and extract + sign/zero extension for loads. Lanes shifted past
// byte 3 are simply dropped.
module ysyx_23060236_lsu_align
  import ysyx_23060236_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  strobe,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [3:0]  strobe_base;

  // Extend the low byte/halfword of a right-justified load word.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = $signed(raw[7:0]);
    half_s = $signed(raw[15:0]);
    case (f3)
      F3_LB:   extend = {{24{byte_s[7]}}, byte_s};
      F3_LH:   extend = {{16{half_s[15]}}, half_s};
      F3_LBU:  extend = {24'd0, raw[7:0]};
      F3_LHU:  extend = {16'd0, raw[15:0]};
      F3_LW:   extend = raw;
      default: extend = raw;
    endcase
  endfunction

  assign shamt   = {offset, 3'b000};
  assign shifted = bus_rdata >> shamt;

  // Strobe pattern before lane alignment, chosen by access size.
  always_comb begin
    case (funct3[1:0])
      SZ_BYTE: strobe_base = 4'b0001;
      SZ_HALF: strobe_base = 4'b0011;
      default: strobe_base = 4'b1111;
    endcase
  end

  assign strobe     = strobe_base << offset;
  assign lane_wdata = store_data << shamt;
  assign load_data  = extend(funct3, shifted);

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store stage: accepts one instruction from EXU at a time, performs at
// most one AXI4-Lite-style data access and returns a registered one-cycle
// writeback / completion pulse. Optional build macro
// YSYX_23060236_LSU_MISALIGN_EN rejects misaligned halfword/word accesses
// without touching the bus.
module ysyx_23060236_lsu
  import ysyx_23060236_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ren,
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        lsu_over,
  output logic        lsu_err
);

  lsu_state_t state, state_next;

  logic        accept;
  logic        bad_align;
  logic        aw_done;
  logic        w_done;
  logic [31:0] load_data;

  // accepted request, held stable until completion
  logic [2:0]  funct3_p0;
  logic [4:0]  rd_p0;
  logic        reg_wen_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] pc_p0;

  assign accept = in_valid & in_ready;

`ifdef YSYX_23060236_LSU_MISALIGN_EN
  assign bad_align = (ren | wen) & misaligned(funct3[1:0], addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  ysyx_23060236_lsu_align u_align (
    .funct3     (funct3_p0),
    .offset     (addr_p0[1:0]),
    .store_data (wdata_p0),
    .bus_rdata  (rdata),
    .strobe     (wstrb),
    .lane_wdata (m_wdata),
    .load_data  (load_data)
  );

  // State register; reset abandons any bus transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: write channels may complete in either order or together.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && !bad_align) begin
          if (ren)      state_next = S_RADDR;
          else if (wen) state_next = S_WREQ;
        end
      end
      S_RADDR: if (arready) state_next = S_RDATA;
      S_RDATA: if (rvalid)  state_next = S_IDLE;
      S_WREQ:  if ((aw_done | awready) && (w_done | wready)) state_next = S_WRESP;
      S_WRESP: if (bvalid)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus handshake outputs decoded from state and per-channel done flags.
  always_comb begin
    in_ready = (state == S_IDLE);
    arvalid  = (state == S_RADDR);
    rready   = (state == S_RDATA);
    awvalid  = (state == S_WREQ) & ~aw_done;
    wvalid   = (state == S_WREQ) & ~w_done;
    bready   = (state == S_WRESP);
  end

  assign araddr = addr_p0;
  assign arsize = {1'b0, funct3_p0[1:0]};
  assign awaddr = addr_p0;
  assign awsize = {1'b0, funct3_p0[1:0]};

  // Remember which write channel has already handshaken; cleared outside WREQ.
  always_ff @(posedge clock) begin
    if (reset || state != S_WREQ) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // ---- stage p0: capture the request at accept ----
  // Latch request fields on accept; data path needs no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      funct3_p0  <= funct3;
      rd_p0      <= rd;
      reg_wen_p0 <= reg_wen;
      addr_p0    <= addr;
      wdata_p0   <= wdata;
      pc_p0      <= pc;
    end
  end

  // ---- stage p1: registered completion / writeback pulse ----
  // One-cycle completion pulse for pass-through, rejected, load and store.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_en    <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      wb_pc    <= 32'd0;
      lsu_over <= 1'b0;
      lsu_err  <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      lsu_over <= 1'b0;
      lsu_err  <= 1'b0;
      if (state == S_IDLE) begin
        if (accept && ((!ren && !wen) || bad_align)) begin
          wb_en    <= reg_wen & ~bad_align;
          wb_rd    <= rd;
          wb_data  <= addr;
          wb_pc    <= pc;
          lsu_over <= 1'b1;
          lsu_err  <= bad_align;
        end
      end else if (state == S_RDATA && rvalid) begin
        wb_en    <= reg_wen_p0 & ~resp_err(rresp);
        wb_rd    <= rd_p0;
        wb_data  <= load_data;
        wb_pc    <= pc_p0;
        lsu_over <= 1'b1;
        lsu_err  <= resp_err(rresp);
      end else if (state == S_WRESP && bvalid) begin
        wb_rd    <= rd_p0;
        wb_pc    <= pc_p0;
        lsu_over <= 1'b1;
        lsu_err  <= resp_err(bresp);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Self-checking bench for ysyx_23060236_lsu: directed cases plus randomized
// instructions, with a bus responder and a behavioural reference model.
module tb_ysyx_23060236_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, ren, wen, reg_wen;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] addr, wdata, pc;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] m_wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc;
  logic        lsu_over, lsu_err;

  int tests = 0;
  int fails = 0;

`ifdef YSYX_23060236_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  ysyx_23060236_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .ren(ren), .wen(wen),
    .funct3(funct3), .rd(rd), .reg_wen(reg_wen), .addr(addr), .wdata(wdata), .pc(pc),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .m_wdata(m_wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .lsu_over(lsu_over), .lsu_err(lsu_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0)      return 1;
    else if (f3[1:0] == 2'd1) return 2;
    else                      return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
    longint v, span;
    int n;
    n = nbytes(f3);
    v = longint'(raw) >> (8 * a[1:0]);
    span = longint'(1) << (8 * n);
    v = v % span;
    if (!f3[2] && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < nbytes(f3); i++)
      if (a[1:0] + i < 4) s[a[1:0] + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [31:0] a);
    longint v;
    v = (longint'(wd) << (8 * a[1:0])) & 64'hFFFF_FFFF;
    return v[31:0];
  endfunction

  // Issue one instruction (kind 0=non-memory, 1=load, 2=store) and play the
  // bus slave with the given wait states. Everything happens on negedges.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv, input logic [1:0] resp,
                       input logic [4:0] rdn, input logic rw,
                       input int d0, input int d1, input int d2, input bit gap);
    logic [31:0] p;
    bit bad, ok, awd, wdn;
    int last;
    p = $urandom;
    bad = MIS_EN && kind != 0 && ref_misaligned(f3, a);
    ok = (resp == 2'b00);
    check("in_ready", in_ready, 1);
    in_valid = 1; ren = (kind == 1); wen = (kind == 2);
    funct3 = f3; addr = a; wdata = wd; rd = rdn; reg_wen = rw; pc = p;
    @(negedge clock);
    in_valid = 0; ren = 0; wen = 0;
    funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    rd = 5'($urandom); reg_wen = 1'($urandom); pc = $urandom;
    if (kind == 0 || bad) begin
      check("nm_over", lsu_over, 1);
      check("nm_err", lsu_err, bad);
      check("nm_wb_en", wb_en, bad ? 1'b0 : rw);
      check("nm_pc", wb_pc, p);
      if (!bad) begin
        check("nm_data", wb_data, a);
        check("nm_rd", wb_rd, rdn);
      end else begin
        check("mis_arvalid", arvalid, 0);
        check("mis_awvalid", awvalid, 0);
        check("mis_wvalid", wvalid, 0);
        check("mis_in_ready", in_ready, 1);
      end
    end else if (kind == 1) begin
      for (int i = 0; i <= d0; i++) begin
        check("arvalid", arvalid, 1);
        check("araddr", araddr, a);
        check("arsize", arsize, {1'b0, f3[1:0]});
        check("ld_wait_over", lsu_over, 0);
        arready = (i == d0);
        @(negedge clock);
      end
      arready = 0;
      for (int i = 0; i <= d1; i++) begin
        check("rready", rready, 1);
        check("ar_dropped", arvalid, 0);
        rvalid = (i == d1);
        rdata = (i == d1) ? rdv : $urandom;
        rresp = (i == d1) ? resp : 2'($urandom);
        @(negedge clock);
      end
      rvalid = 0;
      check("ld_over", lsu_over, 1);
      check("ld_err", lsu_err, !ok);
      check("ld_wb_en", wb_en, rw & ok);
      check("ld_pc", wb_pc, p);
      check("ld_in_ready", in_ready, 1);
      if (ok) begin
        check("ld_data", wb_data, ref_load(f3, a, rdv));
        check("ld_rd", wb_rd, rdn);
      end
    end else begin
      last = (d0 > d1) ? d0 : d1;
      awd = 0; wdn = 0;
      for (int i = 0; i <= last; i++) begin
        check("awvalid", awvalid, !awd);
        check("wvalid", wvalid, !wdn);
        check("awaddr", awaddr, a);
        check("awsize", awsize, {1'b0, f3[1:0]});
        check("wstrb", wstrb, ref_strb(f3, a));
        check("m_wdata", m_wdata, ref_wdata(wd, a));
        check("st_wait_over", lsu_over, 0);
        awready = (i == d0);
        wready = (i == d1);
        @(negedge clock);
        if (i == d0) awd = 1;
        if (i == d1) wdn = 1;
      end
      awready = 0; wready = 0;
      for (int i = 0; i <= d2; i++) begin
        check("bready", bready, 1);
        check("aw_dropped", awvalid, 0);
        check("w_dropped", wvalid, 0);
        check("st_resp_over", lsu_over, 0);
        bvalid = (i == d2);
        bresp = (i == d2) ? resp : 2'($urandom);
        @(negedge clock);
      end
      bvalid = 0;
      check("st_over", lsu_over, 1);
      check("st_err", lsu_err, !ok);
      check("st_wb_en", wb_en, 0);
      check("st_pc", wb_pc, p);
    end
    if (gap) begin
      @(negedge clock);
      check("over_pulse", lsu_over, 0);
      check("wb_pulse", wb_en, 0);
      check("err_pulse", lsu_err, 0);
    end
  endtask

  logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int kind;
    logic [2:0] f3;
    logic [1:0] resp;
    reset = 1; in_valid = 0; ren = 0; wen = 0; funct3 = 0; rd = 0; reg_wen = 0;
    addr = 0; wdata = 0; pc = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_over", lsu_over, 0);
    check("rst_err", lsu_err, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_pc", wb_pc, 0);
    reset = 0;
    @(negedge clock);

    // directed cases
    do_op(0, 3'b000, 32'h0000_1234, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
    do_op(0, 3'b000, 32'hCAFE_0001, 0, 0, 0, 5'd6, 0, 0, 0, 0, 1);
    do_op(1, 3'b000, 32'h8000_0003, 0, 32'h80FF_0000, 0, 5'd1, 1, 0, 0, 0, 1);
    do_op(1, 3'b100, 32'h8000_0003, 0, 32'h80FF_0000, 0, 5'd2, 1, 1, 2, 0, 1);
    do_op(2, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 0, 5'd3, 0, 0, 2, 1, 1);
    do_op(1, 3'b010, 32'h8000_0000, 0, 32'h1234_5678, 2'b10, 5'd4, 1, 0, 0, 0, 1);

    // reset while waiting in RDATA
    in_valid = 1; ren = 1; funct3 = 3'b010; addr = 32'h8000_0010; rd = 5'd7; reg_wen = 1;
    @(negedge clock);
    in_valid = 0; ren = 0;
    check("mid_arvalid", arvalid, 1);
    arready = 1;
    @(negedge clock);
    arready = 0;
    check("mid_rready", rready, 1);
    reset = 1;
    @(negedge clock);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_over", lsu_over, 0);
    reset = 0;
    @(negedge clock);
    check("mid_post_over", lsu_over, 0);
    check("mid_post_rready", rready, 0);
    do_op(1, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 0, 5'd7, 1, 0, 0, 0, 1);

    // misaligned word load (rejected only when the check is built in)
    do_op(1, 3'b010, 32'h8000_0002, 0, 32'hA5A5_5A5A, 0, 5'd8, 1, 0, 0, 0, 1);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) f3 = ld_codes[$urandom_range(0, 4)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom);
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_op(kind, f3, $urandom, $urandom, $urandom, resp, 5'($urandom), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
